// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial pattern generator.
// The FSM state encoding and default widths live here.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_RUN   = 4;

endpackage

// File: rtl/seq_run_tracker.sv
// Tracks the run of identical consumed bits and predicts the Moore
// detector output. z_expect holds its value between consume strobes.
module seq_run_tracker
    import seq_pkg::*;
#(
    parameter int RUN = DEFAULT_RUN
) (
    input  logic Clock,
    input  logic Reset,
    input  logic bit_in,
    input  logic consume,
    input  logic clear,
    output logic z_expect
);

    localparam int RW = $clog2(RUN + 1);

    logic [RW-1:0] run;
    logic [RW-1:0] run_next;
    logic          prev_bit;
    logic          first;

    // The run saturates at RUN so a long constant stream never wraps.
    always_comb begin
        run_next = run;
        if (first || (bit_in != prev_bit)) begin
            run_next = RW'(1);
        end else if (run >= RW'(RUN)) begin
            run_next = RW'(RUN);
        end else begin
            run_next = run + RW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            run      <= '0;
            prev_bit <= 1'b0;
            first    <= 1'b1;
            z_expect <= 1'b0;
        end else if (clear) begin
            run      <= '0;
            first    <= 1'b1;
            z_expect <= 1'b0;
        end else if (consume) begin
            run      <= run_next;
            prev_bit <= bit_in;
            first    <= 1'b0;
            z_expect <= (run_next >= RW'(RUN));
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator feeding a sequence detector, MSB first.
// Define SEQ_GEN_ZEXPECT_EN to include the predicted detector output.
module seq_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int RUN   = DEFAULT_RUN
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [WIDTH-1:0]       Pattern,
    input  logic [$clog2(WIDTH):0] Len,
    output logic                   w_out,
    output logic                   w_valid,
    output logic                   z_expect,
    output logic                   Busy,
    output logic                   Done
);

    localparam int LW = $clog2(WIDTH) + 1;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [LW-1:0]    bit_cnt;
    logic [LW-1:0]    len_clamped;
    logic             accept;
    logic             consume;

    assign len_clamped = (Len > LW'(WIDTH)) ? LW'(WIDTH) : Len;
    assign accept      = (state == IDLE) && Start;
    assign consume     = (state == SHIFT);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length request still produces a single Done pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = (Len == '0) ? DONE : SHIFT;
            SHIFT:   if (bit_cnt == LW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (accept) begin
            shift_reg <= Pattern;
            bit_cnt   <= len_clamped;
        end else if (consume) begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt - LW'(1);
        end
    end

    always_comb begin
        w_out   = 1'b0;
        w_valid = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state)
            SHIFT: begin
                w_out   = shift_reg[WIDTH-1];
                w_valid = 1'b1;
                Busy    = 1'b1;
            end
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

`ifdef SEQ_GEN_ZEXPECT_EN
    seq_run_tracker #(
        .RUN (RUN)
    ) u_run_tracker (
        .Clock    (Clock),
        .Reset    (Reset),
        .bit_in   (shift_reg[WIDTH-1]),
        .consume  (consume),
        .clear    (accept),
        .z_expect (z_expect)
    );
`else
    logic unused_run;
    assign unused_run = (RUN > 0);
    assign z_expect   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_gen.sv
// Directed scoreboard bench for seq_gen; expected z_expect follows
// whether SEQ_GEN_ZEXPECT_EN is defined for the build.
module tb_seq_gen;

    typedef struct packed {
        logic w_out;
        logic w_valid;
        logic z;
        logic busy;
        logic done;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [15:0] Pattern;
    logic [4:0]  Len;
    logic        w_out;
    logic        w_valid;
    logic        z_expect;
    logic        Busy;
    logic        Done;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   failCount = 0;

`ifdef SEQ_GEN_ZEXPECT_EN
    localparam bit Z_EN = 1'b1;
`else
    localparam bit Z_EN = 1'b0;
`endif

    seq_gen #(
        .WIDTH (16),
        .RUN   (4)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Pattern  (Pattern),
        .Len      (Len),
        .w_out    (w_out),
        .w_valid  (w_valid),
        .z_expect (z_expect),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic compareBit(input string tag, input logic observed, input logic expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Reference model: push one entry per cycle from the first bit to the idle cycle after Done.
    task automatic applyStimulus(input logic [15:0] pat, input logic [4:0] len);
        int   n;
        int   run;
        logic prev;
        logic z;
        logic b;
        n    = (len > 5'd16) ? 16 : int'(len);
        run  = 0;
        prev = 1'b0;
        z    = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = pat[15-i];
            expQ.push_back('{w_out: b, w_valid: 1'b1, z: z, busy: 1'b1, done: 1'b0});
            if (i == 0 || b != prev) run = 1;
            else if (run < 4) run = run + 1;
            prev = b;
            z    = Z_EN && (run >= 4);
        end
        expQ.push_back('{w_out: 1'b0, w_valid: 1'b0, z: z, busy: 1'b0, done: 1'b1});
        expQ.push_back('{w_out: 1'b0, w_valid: 1'b0, z: z, busy: 1'b0, done: 1'b0});
        Pattern = pat;
        Len     = len;
        Start   = 1'b1;
        @(posedge Clock);
        #1;
        Start   = 1'b0;
    endtask

    task automatic checkOutput(input int count);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failCount++;
                $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
            end else begin
                e = expQ.pop_front();
                compareBit("w_out",    w_out,    e.w_out);
                compareBit("w_valid",  w_valid,  e.w_valid);
                compareBit("z_expect", z_expect, e.z);
                compareBit("Busy",     Busy,     e.busy);
                compareBit("Done",     Done,     e.done);
            end
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        compareBit({tag, "_w_out"},    w_out,    1'b0);
        compareBit({tag, "_w_valid"},  w_valid,  1'b0);
        compareBit({tag, "_z_expect"}, z_expect, 1'b0);
        compareBit({tag, "_Busy"},     Busy,     1'b0);
        compareBit({tag, "_Done"},     Done,     1'b0);
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b0;
        Pattern = '0;
        Len     = '0;
        #12;
        checkIdleOutputs("reset");
        #1;
        Reset = 1'b0;

        // Start is presented right after reset release and must be taken at the first edge.
        applyStimulus(16'hF0F0, 5'd8);
        checkOutput(expQ.size());

        applyStimulus(16'hAAAA, 5'd16);
        checkOutput(expQ.size());

        applyStimulus(16'hFFFF, 5'd16);
        checkOutput(expQ.size());

        applyStimulus(16'h1234, 5'd0);
        checkOutput(expQ.size());

        applyStimulus(16'h5A3C, 5'd31);
        checkOutput(expQ.size());

        // Start raised through SHIFT and DONE with a different pattern must be ignored.
        applyStimulus(16'hF0F0, 5'd8);
        checkOutput(3);
        Start   = 1'b1;
        Pattern = 16'h0000;
        Len     = 5'd4;
        checkOutput(6);
        Start = 1'b0;
        checkOutput(expQ.size());

        // Asynchronous reset mid-transmission clears outputs before the next edge.
        applyStimulus(16'hFFFF, 5'd16);
        checkOutput(5);
        Reset = 1'b1;
        #1;
        checkIdleOutputs("midreset");
        expQ.delete();
        #1;
        Reset = 1'b0;
        applyStimulus(16'hC3A5, 5'd16);
        checkOutput(expQ.size());

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the maximum pattern length in bits.
REQ-002 SHALL have parameter RUN, default 4, meaning the run length of identical bits that raises the predicted detect flag.
REQ-003 SHALL have port Clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  meaning a request to transmit; sampled only in IDLE.
REQ-006 SHALL have port Pattern  input  WIDTH  meaning the bits to send, MSB first.
REQ-007 SHALL have port Len  input  $clog2(WIDTH)+1  meaning the number of bits to send.
REQ-008 SHALL have port w_out  output  1  meaning the serial bit, intended to drive a sequence detector's w input.
REQ-009 SHALL have port w_valid  output  1  meaning w_out carries a pattern bit this cycle.
REQ-010 SHALL have port z_expect  output  1  meaning the predicted Moore detector output.
REQ-011 SHALL have port Busy  output  1  meaning a transmission is in progress.
REQ-012 SHALL have port Done  output  1  meaning a one-cycle pulse at transmission end.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL, in IDLE with Start=1 at an edge, latch Pattern and min(Len,WIDTH), clear the run tracker and z_expect, and go to SHIFT.
REQ-015 SHALL, in IDLE with Start=1 at an edge and Len=0, go directly to DONE with no valid bits.
REQ-016 SHALL, in SHIFT, drive w_valid=1 and w_out=the current MSB, with Busy=1.
REQ-017 SHALL have the first bit appear in the cycle after Start is accepted (latency 1).
REQ-018 SHALL shift the pattern left by one bit at each edge in SHIFT.
REQ-019 SHALL go from SHIFT to DONE at the edge that consumes the final bit.
REQ-020 SHALL hold Done=1 and Busy=0 for exactly one cycle in DONE, then go to IDLE.
REQ-021 SHALL ignore Start in SHIFT and DONE; it is not queued.
REQ-022 SHALL drive w_out=0, w_valid=0 and Busy=0 outside SHIFT.
REQ-023 SHALL, at each edge that consumes a bit b, set run := 1 if b is the first bit or differs from the previous bit, else run := min(run+1, RUN).
REQ-024 SHALL set z_expect := (run >= RUN) at that same edge, so z_expect is high in the cycle after the RUN-th identical bit, matching detector timing.
REQ-025 SHALL hold z_expect after DONE until the next accepted Start or reset.
REQ-026 SHALL saturate the run counter; it never wraps.
REQ-027 SHALL clamp a Len value greater than WIDTH to WIDTH.

Reset
REQ-028 SHALL, on Reset=1 (asynchronous and immediate, including mid-transmission), force state IDLE and clear the shift register, bit counter and run counter.
REQ-029 SHALL, on Reset=1, force w_out=0, w_valid=0, z_expect=0, Busy=0 and Done=0.
REQ-030 SHALL, after Reset is deasserted, accept Start at the first following edge.

Configuration
REQ-031 SHALL include the run tracker and z_expect logic per REQ-023 to REQ-026 when macro SEQ_GEN_ZEXPECT_EN is defined.
REQ-032 SHALL, when SEQ_GEN_ZEXPECT_EN is undefined, tie z_expect to 0, omit the run tracker, and leave all other timing unchanged.

Structure
REQ-033 SHALL place the state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default RUN constant in shared package seq_pkg.
REQ-034 SHALL implement the run tracker as sub-module seq_run_tracker (inputs: bit, consume strobe, clear; output: z_expect), instantiated only under SEQ_GEN_ZEXPECT_EN.

Verification
REQ-035 SHALL verify: Pattern=16'hF0F0, Len=8 -> bits 1,1,1,1,0,0,0,0; z_expect=1 in the cycles after bits 4 and 8, 0 otherwise; Done pulses once, 9 cycles after Start.
REQ-036 SHALL verify: Pattern=16'hAAAA, Len=16 -> alternating bits; z_expect never 1; Busy high for exactly 16 cycles.
REQ-037 SHALL verify: Pattern=16'hFFFF, Len=16 -> z_expect rises after bit 4 and stays 1 through DONE (saturation, no wrap).
REQ-038 SHALL verify: Len=0 -> no w_valid cycles; Done pulses in the cycle after Start; Len=31 -> exactly 16 bits sent.
REQ-039 SHALL verify: Start re-asserted during SHIFT -> ignored; Reset pulsed mid-SHIFT -> all outputs 0 immediately; a new Start then sends the full pattern from the MSB.
REQ-040 SHALL verify: build without SEQ_GEN_ZEXPECT_EN, repeat REQ-035 -> identical w_out, w_valid and Done, with z_expect constant 0.
